// File: rtl/crc_stream_check.sv
// Byte-serial CRC-12 checker: folds one byte per accepted beat, then reports the CRC, a match flag and a length flag.
// Latency: the result is registered on the edge that accepts the last beat, so res_valid_o rises the cycle after that beat.
// Backpressure: data_ready_o drops while a result is pending; a new string starts only after the result is consumed.
//
// Ports:
//   clk_i, srst_n_i             clock and synchronous active-low reset
//   data_i/data_valid_i/
//   data_last_i/data_ready_o    byte stream in; exp_crc_i is sampled only on the accepted last beat
//   res_valid_o/res_ready_i     one-entry result handshake carrying res_o, match_o, len_err_o

package crc_pkg;
    localparam int CRC_W = 12;
    localparam logic [CRC_W-1:0] POLY = 12'hD95;

    // MSB-first, non-reflected, no final XOR. The byte is XORed into the top
    // bits of the register, then eight polynomial-division steps follow.
    function automatic logic [CRC_W-1:0] crc_8d95(input logic [7:0] data,
                                                  input logic [CRC_W-1:0] crc);
        logic [CRC_W-1:0] c;
        c = crc ^ {data, 4'b0000};
        for (int i = 0; i < 8; i++) begin
            if (c[CRC_W-1]) c = {c[CRC_W-2:0], 1'b0} ^ POLY;
            else            c = {c[CRC_W-2:0], 1'b0};
        end
        return c;
    endfunction
endpackage

module crc_stream_check #(
    parameter int BYTE_W   = 8,
    parameter int WIDTH    = 12,
    parameter int INIT     = 1,
    parameter int STR_SIZE = 20
) (
    input  logic              clk_i,
    input  logic              srst_n_i,
    input  logic [BYTE_W-1:0] data_i,
    input  logic              data_valid_i,
    input  logic              data_last_i,
    input  logic [WIDTH-1:0]  exp_crc_i,
    output logic              data_ready_o,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [WIDTH-1:0]  res_o,
    output logic              match_o,
    output logic              len_err_o
);
    localparam int CNT_W = $clog2(STR_SIZE + 2);
    localparam logic [WIDTH-1:0] INIT_V  = WIDTH'(INIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STR_SIZE + 1);
    localparam logic [CNT_W-1:0] CNT_EXP = CNT_W'(STR_SIZE);

    generate
        if (INIT >= (1 << WIDTH)) begin : g_bad_init
            $error("crc_stream_check: INIT does not fit in WIDTH bits");
        end
        if (WIDTH != crc_pkg::CRC_W || BYTE_W != 8) begin : g_bad_width
            $error("crc_stream_check: crc_8d95 needs WIDTH=12 and BYTE_W=8");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t            state_q, state_nxt;
    logic [WIDTH-1:0]  crc_q, crc_nxt;
    logic [CNT_W-1:0]  cnt_q, cnt_nxt;
    logic [WIDTH-1:0]  exp_q, exp_nxt;
    logic              rv_q, rv_nxt;
    logic [WIDTH-1:0]  res_q, res_nxt;
    logic              match_q, match_nxt;
    logic              lerr_q, lerr_nxt;

    logic              accept;
    logic [WIDTH-1:0]  fold;
    logic [CNT_W-1:0]  cnt_inc;

    // Ready is a function of state only; the reset term keeps it low while
    // the synchronous reset is being applied.
    assign data_ready_o = srst_n_i && (state_q != DONE);
    assign accept       = data_valid_i && data_ready_o;

    // The first byte of a string always folds from the seed, so a stale crc_q
    // can never leak into a new string.
    assign fold    = crc_pkg::crc_8d95(data_i, (state_q == IDLE) ? INIT_V : crc_q);
    assign cnt_inc = (state_q == IDLE) ? CNT_W'(1) :
                     (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_nxt = state_q;
        crc_nxt   = crc_q;
        cnt_nxt   = cnt_q;
        exp_nxt   = exp_q;
        rv_nxt    = rv_q;
        res_nxt   = res_q;
        match_nxt = match_q;
        lerr_nxt  = lerr_q;
        case (state_q)
            IDLE, ACC: begin
                if (accept) begin
                    crc_nxt = fold;
                    cnt_nxt = cnt_inc;
                    if (data_last_i) begin
                        exp_nxt   = exp_crc_i;
                        state_nxt = DONE;
                        rv_nxt    = 1'b1;
                        res_nxt   = fold;
                        match_nxt = (fold == exp_crc_i);
                        lerr_nxt  = (cnt_inc != CNT_EXP);
                    end else begin
                        state_nxt = ACC;
                    end
                end
            end
            DONE: begin
                if (res_ready_i) begin
                    state_nxt = IDLE;
                    crc_nxt   = INIT_V;
                    cnt_nxt   = '0;
                    rv_nxt    = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            state_q <= IDLE;
            crc_q   <= INIT_V;
            cnt_q   <= '0;
            exp_q   <= '0;
            rv_q    <= 1'b0;
            res_q   <= '0;
            match_q <= 1'b0;
            lerr_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            crc_q   <= crc_nxt;
            cnt_q   <= cnt_nxt;
            exp_q   <= exp_nxt;
            rv_q    <= rv_nxt;
            res_q   <= res_nxt;
            match_q <= match_nxt;
            lerr_q  <= lerr_nxt;
        end
    end

    assign res_valid_o = rv_q;
    assign res_o       = res_q;
    assign match_o     = match_q;
    assign len_err_o   = lerr_q;
endmodule
